// File: rtl/dm_pkg.sv
// dm_pkg: shared types, widths and the byte-merge helper for the data-memory
// responder. Imported by dm_responder and its testbench-facing interface.
package dm_pkg;

  localparam int DM_WORD_W = 32;
  localparam int DM_BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_t;

  // Replace each byte lane of old_word whose enable is set with the same lane of wdata.
  function automatic logic [DM_WORD_W-1:0] dm_merge_be(
    input logic [DM_WORD_W-1:0] old_word,
    input logic [DM_WORD_W-1:0] wdata,
    input logic [DM_BE_W-1:0]   be
  );
    logic [DM_WORD_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < DM_BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dm_if.sv
// dm_if: load/store request and response bundle between the MIPS core (master)
// and the data-memory responder (slave). No response backpressure.
interface dm_if;
  import dm_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [31:0]          req_addr;
  logic [DM_BE_W-1:0]   req_be;
  logic [DM_WORD_W-1:0] req_wdata;
  logic                 resp_valid;
  logic [DM_WORD_W-1:0] resp_rdata;
  logic                 resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dm_wait_ctr.sv
// dm_wait_ctr: 4-bit loadable down-counter pacing the responder's wait states.
// Load has priority over decrement; the count saturates at zero.
module dm_wait_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count,
  output logic       zero
);

  logic [3:0] count_q, count_d;

  // Next count: reload, step down, or hold.
  always_comb begin
    // NOTE: default assignment first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so all flops update together.
    if (reset) count_q <= 4'd0;
    else       count_q <= count_d;
  end

  assign count = count_q;
  assign zero  = (count_q == 4'd0);

endmodule

// File: rtl/dm_responder.sv
// dm_responder: memory-side end of the core's load/store interface.
// One request at a time; word-addressed storage with byte-lane writes;
// single-cycle response pulse carrying read data or an error flag.
// Optional build macro DM_WAIT_STATES_EN inserts WAIT_CYCLES wait states
// per access via the dm_wait_ctr sub-module.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  dm_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dm_state_t            state_q, state_d;
  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [DM_WORD_W-1:0] resp_rdata_q, resp_rdata_d;
  logic                 resp_err_q, resp_err_d;

  // Request fields captured at the handshake.
  logic                 we_q, we_d;
  logic [29:0]          idx_q, idx_d;
  logic [DM_BE_W-1:0]   be_q, be_d;
  logic [DM_WORD_W-1:0] wdata_q, wdata_d;

  logic [DM_WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic                 mem_we;
  logic [IDX_W-1:0]     mem_widx;
  logic [DM_WORD_W-1:0] mem_wdata;

  // Fields the response is formed from (live inputs on a zero-wait accept).
  logic                 go_resp;
  logic                 rsp_we;
  logic [29:0]          rsp_idx;
  logic [DM_BE_W-1:0]   rsp_be;

  // Out-of-range word index or no byte enabled rejects the access.
  function automatic logic is_err(input logic [29:0] idx, input logic [DM_BE_W-1:0] be);
    return ({2'b00, idx} >= 32'(DEPTH_WORDS)) || (be == '0);
  endfunction

`ifdef DM_WAIT_STATES_EN
  logic       ctr_load, ctr_dec, ctr_zero;
  logic [3:0] ctr_count;

  dm_wait_ctr u_wait_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (4'(WAIT_CYCLES)),
    .dec      (ctr_dec),
    .count    (ctr_count),
    .zero     (ctr_zero)
  );
`endif

  // FSM next-state, capture of request fields, response formation and store commit.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    idx_d        = idx_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    go_resp      = 1'b0;
    rsp_we       = we_q;
    rsp_idx      = idx_q;
    rsp_be       = be_q;
    mem_we       = 1'b0;
    mem_widx     = idx_q[IDX_W-1:0];
    mem_wdata    = dm_merge_be(mem_q[idx_q[IDX_W-1:0]], wdata_q, be_q);
`ifdef DM_WAIT_STATES_EN
    ctr_load     = 1'b0;
    ctr_dec      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          we_d    = bus.req_we;
          idx_d   = bus.req_addr[31:2];
          be_d    = bus.req_be;
          wdata_d = bus.req_wdata;
`ifdef DM_WAIT_STATES_EN
          if (WAIT_CYCLES != 0) begin
            state_d  = WAIT;
            ctr_load = 1'b1;
          end else begin
            go_resp = 1'b1;
            rsp_we  = bus.req_we;
            rsp_idx = bus.req_addr[31:2];
            rsp_be  = bus.req_be;
          end
`else
          go_resp = 1'b1;
          rsp_we  = bus.req_we;
          rsp_idx = bus.req_addr[31:2];
          rsp_be  = bus.req_be;
`endif
        end
      end
`ifdef DM_WAIT_STATES_EN
      WAIT: begin
        if (ctr_zero || (ctr_count == 4'd1)) go_resp = 1'b1;
        else                                 ctr_dec = 1'b1;
      end
`endif
      RESP: begin
        state_d = IDLE;
        mem_we  = we_q && !is_err(idx_q, be_q);
      end
      default: state_d = IDLE;
    endcase

    // Entering RESP: register the response so it is visible for exactly that cycle.
    if (go_resp) begin
      state_d      = RESP;
      resp_valid_d = 1'b1;
      resp_err_d   = is_err(rsp_idx, rsp_be);
      if (!rsp_we && !resp_err_d) resp_rdata_d = mem_q[rsp_idx[IDX_W-1:0]];
    end

    req_ready_d = (state_d == IDLE);
  end

  // Control and output registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      we_q         <= we_d;
      idx_q        <= idx_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
    end
  end

  // Storage array: cleared by reset, written once per legal store at the RESP edge.
  always_ff @(posedge clk) begin
    // NOTE: memory contents must read as zero after reset, so every word is cleared here;
    // this forces a flop-based array rather than an inferred RAM macro.
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  // Byte-offset address bits do not select storage.
  logic unused_ok;
`ifdef DM_WAIT_STATES_EN
  assign unused_ok = ^{1'b0, bus.req_addr[1:0]};
`else
  assign unused_ok = ^{1'b0, bus.req_addr[1:0], 4'(WAIT_CYCLES)};
`endif

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: randomized and directed checks of dm_responder against a
// word-array reference model with byte-granular store semantics.
// Honours DM_WAIT_STATES_EN the same way as the design.
module tb_dm_responder;

  localparam int DEPTH = 1024;
`ifdef DM_WAIT_STATES_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] got_rdata;
  logic        got_err;

  dm_if bus ();

  dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
  endtask

  function automatic logic model_err(input logic [31:0] addr, input logic [3:0] be);
    return ((addr >> 2) >= DEPTH) || (be == 4'h0);
  endfunction

  task automatic drive_idle_junk();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom_range(0, 1));
    bus.req_addr  = $urandom;
    bus.req_be    = 4'($urandom_range(0, 15));
    bus.req_wdata = $urandom;
  endtask

  // One complete access: handshake, latency, response contents, pulse width, model update.
  task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd);
    int          n;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [7:0]  bytes [4];
    exp_err = model_err(addr, be);
    exp_rd  = (we || exp_err) ? 32'h0 : ref_mem[addr >> 2];
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_be    = be;
    bus.req_wdata = wd;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("ready_timeout", 32'(bus.req_ready), 32'h1);
      drive_idle_junk();
      return;
    end
    @(posedge clk);
    @(negedge clk);
    drive_idle_junk();
    n = 1;
    while (!bus.resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(1 + W));
    check("resp_err", 32'(bus.resp_err), 32'(exp_err));
    check("resp_rdata", bus.resp_rdata, exp_rd);
    got_rdata = bus.resp_rdata;
    got_err   = bus.resp_err;
    @(negedge clk);
    check("resp_pulse", 32'(bus.resp_valid), 32'h0);
    if (we && !exp_err) begin
      for (int b = 0; b < 4; b++) bytes[b] = ref_mem[addr >> 2][8*b +: 8];
      for (int b = 0; b < 4; b++) if (be[b]) bytes[b] = wd[8*b +: 8];
      ref_mem[addr >> 2] = {bytes[3], bytes[2], bytes[1], bytes[0]};
    end
  endtask

  initial begin
    logic [31:0] addrs [3];
    logic [31:0] a;
    int k, nresp, last;
    logic acc;

    drive_idle_junk();
    model_clear();

    // Reset: ready low while reset is held, high once released.
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_ready", 32'(bus.req_ready), 32'h0);
      check("rst_valid", 32'(bus.resp_valid), 32'h0);
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_ready", 32'(bus.req_ready), 32'h1);
    check("post_rst_rdata", bus.resp_rdata, 32'h0);
    check("post_rst_err", 32'(bus.resp_err), 32'h0);
    access(1'b0, 32'h0, 4'hF, 32'h0);
    check("load0", got_rdata, 32'h0);

    // Word store and reload.
    access(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    access(1'b0, 32'h10, 4'h0 + 4'h1, 32'h0);
    check("word_load", got_rdata, 32'hDEADBEEF);

    // Byte-lane merge.
    access(1'b1, 32'h20, 4'hF, 32'h11223344);
    access(1'b1, 32'h22, 4'b0101, 32'hAABBCCDD);
    access(1'b0, 32'h20, 4'hF, 32'h0);
    check("lane_merge", got_rdata, 32'h11BB33DD);

    // Errors: out of range, and empty byte enable leaves memory intact.
    access(1'b0, 32'h1000, 4'hF, 32'h0);
    check("oob_err", 32'(got_err), 32'h1);
    access(1'b1, 32'h10, 4'h0, 32'h01234567);
    check("be0_err", 32'(got_err), 32'h1);
    access(1'b0, 32'h10, 4'hF, 32'h0);
    check("be0_unchanged", got_rdata, 32'hDEADBEEF);
    access(1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0);
    check("top_addr_err", 32'(got_err), 32'h1);
    access(1'b0, 32'h0FFC, 4'hF, 32'h0);
    check("last_word_ok", 32'(got_err), 32'h0);

    // Reset in the cycle after accept aborts the store and clears memory.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h30;
    bus.req_be    = 4'hF;
    bus.req_wdata = 32'h5;
    @(posedge clk);
    @(negedge clk);
    drive_idle_junk();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 3 + W; i++) begin
      check("abort_no_resp", 32'(bus.resp_valid), 32'h0);
      @(negedge clk);
    end
    access(1'b0, 32'h30, 4'hF, 32'h0);
    check("abort_discard", got_rdata, 32'h0);
    access(1'b0, 32'h10, 4'hF, 32'h0);
    check("rst_clears_mem", got_rdata, 32'h0);

    // Back-to-back loads with req_valid held high.
    addrs[0] = 32'h40;
    addrs[1] = 32'h44;
    addrs[2] = 32'h48;
    for (int i = 0; i < 3; i++) access(1'b1, addrs[i], 4'hF, $urandom);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_be    = 4'hF;
    bus.req_addr  = addrs[0];
    k = 0;
    nresp = 0;
    last = -100;
    for (int t = 0; t < 12 * (2 + W) && nresp < 3; t++) begin
      if (bus.resp_valid) begin
        a = addrs[nresp];
        check("b2b_rdata", bus.resp_rdata, ref_mem[a >> 2]);
        check("b2b_ready_resp", 32'(bus.req_ready), 32'h0);
        nresp++;
      end
      if (t == last + 1) check("b2b_ready_busy", 32'(bus.req_ready), 32'h0);
      acc = bus.req_valid && bus.req_ready;
      if (acc) begin
        if (k > 0) check("b2b_gap", 32'(t - last), 32'(2 + W));
        last = t;
        k++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (k < 3) bus.req_addr = addrs[k];
        else       bus.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_accepts", 32'(k), 32'h3);
    check("b2b_resps", 32'(nresp), 32'h3);
    drive_idle_junk();

    // Randomized mix of loads and stores, mostly in a small window, some rejected.
    for (int i = 0; i < 80; i++) begin
      logic [31:0] ra;
      if ($urandom_range(0, 7) == 0) ra = (32'(DEPTH) + 32'($urandom_range(0, 4000))) << 2;
      else                           ra = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Synthesizable data-memory responder for the pipelined MIPS core: the memory-side end of the core's load/store request interface. It accepts one request at a time via a valid/ready handshake, holds word-addressed storage with byte-lane writes, and returns a single-cycle response pulse with read data or an error flag. The core stalls its MEM stage until the response pulse arrives, so the interface has no response backpressure.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words (4 KiB); power of two.
- WAIT_CYCLES, 2, extra wait states per access when wait states are compiled in; range 0–15.
- clk  input  1  system clock; all logic updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; bits [1:0] ignored for indexing.
- req_be  input  4  byte enables; lane i = bits [8i+7:8i].
- req_wdata  input  32  store data, lane-aligned.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  full word read (loads); 0 for stores and errors.
- resp_err  output  1  valid with resp_valid; access rejected.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. Handshake fires when req_valid && req_ready. On fire, latch we/addr/be/wdata; go to WAIT if the wait counter is nonzero, else RESP.
- WAIT: req_ready=0; counter decrements each cycle; go to RESP when it reaches 1.
- RESP: resp_valid=1 for exactly this cycle; return to IDLE on the next edge. No new request is accepted in RESP.
- Error when word index (addr[31:2]) >= DEPTH_WORDS, or be == 4'b0000. On error: memory unchanged, resp_rdata=0, resp_err=1.
- Legal store: bytes with be[i]=1 are written from req_wdata lane i at the RESP edge. Other bytes are unchanged. resp_rdata=0.
- Legal load: resp_rdata = the full stored word, sampled in RESP. be is ignored for reads; the core performs byte/half extraction.
- Reset: all outputs go to 0 and state goes to IDLE. All memory words are cleared to 0 in the same cycle.
- Reset asserted mid-access (WAIT or RESP) aborts the access. The pending store is discarded and no resp_valid is produced.
- Request inputs outside the IDLE handshake are ignored.

## Timing
- Reset values: req_ready=0 while reset is high and 1 on the first cycle after. resp_valid=0, resp_rdata=0, resp_err=0.
- Accept at edge N.
- resp_valid is high during cycle N+1+W, where W=WAIT_CYCLES with the macro and W=0 without it.
- The earliest next accept is at edge N+2+W.
- A store is visible to a load accepted at edge N+2+W or later.
- All outputs are registered; there is no combinational path from request inputs to outputs.

## Configuration
- DM_WAIT_STATES_EN defined: the WAIT state and wait counter exist, and each access takes WAIT_CYCLES extra cycles.
- DM_WAIT_STATES_EN undefined: WAIT state and counter are removed. IDLE→RESP always, with a fixed single-cycle response after accept. WAIT_CYCLES is ignored.

## Structure
- Package dm_pkg holds:
  - state enum dm_state_t {IDLE, WAIT, RESP};
  - DM_WORD_W=32 and DM_BE_W=4;
  - function dm_merge_be(old, wdata, be) for the byte merge.
- Sub-module dm_wait_ctr: 4-bit loadable down-counter with load, dec and zero outputs. Instantiated only under DM_WAIT_STATES_EN.
- The memory array and FSM live in dm_responder.

## Test plan
- Reset then idle: reset high 2 cycles → req_ready=0 during reset and 1 after; resp_valid=0; a load of addr 0x0 returns 0x00000000.
- Store/load word: store 0xDEADBEEF to 0x10 with be=4'b1111, then load 0x10 → resp_rdata=0xDEADBEEF, resp_err=0. resp_valid arrives 1+W cycles after each accept.
- Byte lanes: word 0x20 holds 0x11223344; store wdata=0xAABBCCDD with be=4'b0101 → load returns 0x11BB33DD.
- Errors: load at byte address 0x1000 (index 1024) → resp_err=1, rdata=0. Store with be=0 to 0x10 → resp_err=1, and word 0x10 is unchanged.
- Mid-access reset: with the macro and WAIT_CYCLES=2, store 0x5 to 0x30, then assert reset in the WAIT cycle → no resp_valid, and a later load of 0x30 returns 0.
- Back-to-back: req_valid held high with 3 loads queued → exactly one accept per 2+W cycles, and req_ready=0 in WAIT and RESP.
